// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller:
// long-op FSM encoding, hazard-cause debug enum and limits.
package core_ctrl_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_LONG = 1'b1
    } ctrl_state_e;

    typedef enum logic [2:0] {
        CAUSE_NONE    = 3'd0,
        CAUSE_DMEM    = 3'd1,
        CAUSE_LONG    = 3'd2,
        CAUSE_BRANCH  = 3'd3,
        CAUSE_LOADUSE = 3'd4,
        CAUSE_IMEM    = 3'd5
    } hazard_cause_e;

    localparam int LONG_LAT_MAX = 64;
    localparam int LONG_CNT_W   = 6;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: flags an ID-stage source register that
// matches the destination of a load currently in EX.
module load_use_detect (
    input  logic [4:0] i_rs1,
    input  logic [4:0] i_rs2,
    input  logic       i_rs1_used,
    input  logic       i_rs2_used,
    input  logic [4:0] i_rd,
    input  logic       i_reg_wb_en,
    input  logic       i_is_load,
    output logic       o_hazard
);

    logic w_rs1_match;
    logic w_rs2_match;

    assign w_rs1_match = i_rs1_used && (i_rd == i_rs1);
    assign w_rs2_match = i_rs2_used && (i_rd == i_rs2);

    // x0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign o_hazard = i_is_load && i_reg_wb_en && (i_rd != 5'd0)
                      && (w_rs1_match || w_rs2_match);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Central pipeline stall/flush controller: priority-resolves dmem busywait,
// long ops, taken branches, load-use and imem busywait; counts stall cycles.
module hazard_stall_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int LONG_LAT = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       rs1_label_if_id_i,
    input  logic [4:0]       rs2_label_if_id_i,
    input  logic             rs1_used_i,
    input  logic             rs2_used_i,
    input  logic [4:0]       rd_id_ex_i,
    input  logic             reg_wb_en_id_ex_i,
    input  logic             is_load_instruction_id_ex_i,
    input  logic             is_long_id_ex_i,
    input  logic             branch_taken_i,
    input  logic             imem_busywait_i,
    input  logic             dmem_busywait_i,
    output logic             pc_stall_o,
    output logic             if_id_stall_o,
    output logic             if_id_flush_o,
    output logic             id_ex_stall_o,
    output logic             id_ex_flush_o,
    output logic             ex_mem_bubble_o,
    output logic             back_stall_o,
    output logic             long_busy_o,
    output logic [CNT_W-1:0] stall_cycles_o
);

    if (LONG_LAT < 1 || LONG_LAT > LONG_LAT_MAX) begin : g_bad_lat
        $error("hazard_stall_ctrl: LONG_LAT out of range 1..64");
    end

    localparam bit                    LONG_EN   = (LONG_LAT >= 2);
    localparam logic [LONG_CNT_W-1:0] LONG_INIT = LONG_CNT_W'(LONG_EN ? LONG_LAT - 2 : 0);

    ctrl_state_e             r_state;
    ctrl_state_e             w_state_nxt;
    logic [LONG_CNT_W-1:0]   r_cnt;
    logic [LONG_CNT_W-1:0]   w_cnt_nxt;
    logic [CNT_W-1:0]        r_stall_cycles;
    logic                    w_load_use;
    logic                    w_long_entry;
    logic                    w_long_stall;
    hazard_cause_e           w_cause;

    load_use_detect u_load_use_detect (
        .i_rs1       (rs1_label_if_id_i),
        .i_rs2       (rs2_label_if_id_i),
        .i_rs1_used  (rs1_used_i),
        .i_rs2_used  (rs2_used_i),
        .i_rd        (rd_id_ex_i),
        .i_reg_wb_en (reg_wb_en_id_ex_i),
        .i_is_load   (is_load_instruction_id_ex_i),
        .o_hazard    (w_load_use)
    );

    assign w_long_entry = LONG_EN && (r_state == ST_RUN) && is_long_id_ex_i;
    assign w_long_stall = w_long_entry || ((r_state == ST_LONG) && (r_cnt != '0));

    // The LONG cycle with cnt==0 is the release cycle: no stall, back to RUN.
    always_comb begin
        // NOTE: every combinational target gets a default first so no path leaves it unassigned (no latch).
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (!dmem_busywait_i) begin
            case (r_state)
                ST_RUN: begin
                    if (w_long_entry) begin
                        w_state_nxt = ST_LONG;
                        w_cnt_nxt   = LONG_INIT;
                    end
                end
                ST_LONG: begin
                    if (r_cnt != '0) w_cnt_nxt = r_cnt - LONG_CNT_W'(1);
                    else             w_state_nxt = ST_RUN;
                end
                default: w_state_nxt = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
        if (rst_i) begin
            r_state        <= ST_RUN;
            r_cnt          <= '0;
            r_stall_cycles <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (pc_stall_o && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_cause = CAUSE_NONE;
        if      (dmem_busywait_i) w_cause = CAUSE_DMEM;
        else if (w_long_stall)    w_cause = CAUSE_LONG;
        else if (branch_taken_i)  w_cause = CAUSE_BRANCH;
        else if (w_load_use)      w_cause = CAUSE_LOADUSE;
        else if (imem_busywait_i) w_cause = CAUSE_IMEM;
    end

    // Exactly one cause drives the controls, so a flush and a stall on the same register never coincide.
    always_comb begin
        pc_stall_o      = 1'b0;
        if_id_stall_o   = 1'b0;
        if_id_flush_o   = 1'b0;
        id_ex_stall_o   = 1'b0;
        id_ex_flush_o   = 1'b0;
        ex_mem_bubble_o = 1'b0;
        back_stall_o    = 1'b0;
        if (rst_i) begin
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
        end else begin
            case (w_cause)
                CAUSE_DMEM: begin
                    pc_stall_o    = 1'b1;
                    if_id_stall_o = 1'b1;
                    id_ex_stall_o = 1'b1;
                    back_stall_o  = 1'b1;
                end
                CAUSE_LONG: begin
                    pc_stall_o      = 1'b1;
                    if_id_stall_o   = 1'b1;
                    id_ex_stall_o   = 1'b1;
                    ex_mem_bubble_o = 1'b1;
                end
                CAUSE_BRANCH: begin
                    if_id_flush_o = 1'b1;
                    id_ex_flush_o = 1'b1;
                end
                CAUSE_LOADUSE: begin
                    pc_stall_o    = 1'b1;
                    if_id_stall_o = 1'b1;
                    id_ex_flush_o = 1'b1;
                end
                CAUSE_IMEM: begin
                    pc_stall_o    = 1'b1;
                    if_id_flush_o = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign long_busy_o    = !rst_i && (r_state == ST_LONG);
    assign stall_cycles_o = r_stall_cycles;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios followed by
// random traffic, both compared cycle by cycle against a behavioural model.
module tb_hazard_stall_ctrl;

    localparam int LAT = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1, rs2, rd;
    logic       rs1_used, rs2_used, wb_en, is_load, is_long;
    logic       branch, imem, dmem;

    logic        pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic        ex_mem_bubble, back_stall, long_busy;
    logic [15:0] stall_cnt;

    logic        s_pc_stall, s_if_id_stall, s_if_id_flush, s_id_ex_stall, s_id_ex_flush;
    logic        s_ex_mem_bubble, s_back_stall, s_long_busy;
    logic [3:0]  s_stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Model: age of the long op in EX (non-frozen cycles spent), and total stall cycles.
    int m_age    = 0;
    int m_stalls = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.LONG_LAT(LAT), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst),
        .rs1_label_if_id_i(rs1), .rs2_label_if_id_i(rs2),
        .rs1_used_i(rs1_used), .rs2_used_i(rs2_used),
        .rd_id_ex_i(rd), .reg_wb_en_id_ex_i(wb_en),
        .is_load_instruction_id_ex_i(is_load), .is_long_id_ex_i(is_long),
        .branch_taken_i(branch), .imem_busywait_i(imem), .dmem_busywait_i(dmem),
        .pc_stall_o(pc_stall), .if_id_stall_o(if_id_stall), .if_id_flush_o(if_id_flush),
        .id_ex_stall_o(id_ex_stall), .id_ex_flush_o(id_ex_flush),
        .ex_mem_bubble_o(ex_mem_bubble), .back_stall_o(back_stall),
        .long_busy_o(long_busy), .stall_cycles_o(stall_cnt)
    );

    hazard_stall_ctrl #(.LONG_LAT(LAT), .CNT_W(4)) dut_sat (
        .clk_i(clk), .rst_i(rst),
        .rs1_label_if_id_i(rs1), .rs2_label_if_id_i(rs2),
        .rs1_used_i(rs1_used), .rs2_used_i(rs2_used),
        .rd_id_ex_i(rd), .reg_wb_en_id_ex_i(wb_en),
        .is_load_instruction_id_ex_i(is_load), .is_long_id_ex_i(is_long),
        .branch_taken_i(branch), .imem_busywait_i(imem), .dmem_busywait_i(dmem),
        .pc_stall_o(s_pc_stall), .if_id_stall_o(s_if_id_stall), .if_id_flush_o(s_if_id_flush),
        .id_ex_stall_o(s_id_ex_stall), .id_ex_flush_o(s_id_ex_flush),
        .ex_mem_bubble_o(s_ex_mem_bubble), .back_stall_o(s_back_stall),
        .long_busy_o(s_long_busy), .stall_cycles_o(s_stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        rst = 1'b0; rs1 = '0; rs2 = '0; rd = '0;
        rs1_used = 1'b0; rs2_used = 1'b0; wb_en = 1'b0; is_load = 1'b0;
        is_long = 1'b0; branch = 1'b0; imem = 1'b0; dmem = 1'b0;
    endtask

    // One clock: check outputs mid-cycle against the model, advance the model, cross the edge.
    task automatic cycle(input string tag);
        logic lu, busy, lstall;
        logic e_pc, e_ifs, e_iff, e_ids, e_idf, e_bub, e_back;
        @(negedge clk);
        lu = is_load && wb_en && (rd != 0) &&
             ((rs1_used && rd == rs1) || (rs2_used && rd == rs2));
        busy   = (m_age >= 1);
        lstall = busy ? (m_age < LAT - 1) : (is_long && LAT >= 2);
        {e_pc, e_ifs, e_iff, e_ids, e_idf, e_bub, e_back} = '0;
        if (rst)              begin e_iff = 1; e_idf = 1; end
        else if (dmem)        begin e_pc = 1; e_ifs = 1; e_ids = 1; e_back = 1; end
        else if (lstall)      begin e_pc = 1; e_ifs = 1; e_ids = 1; e_bub = 1; end
        else if (branch)      begin e_iff = 1; e_idf = 1; end
        else if (lu)          begin e_pc = 1; e_ifs = 1; e_idf = 1; end
        else if (imem)        begin e_pc = 1; e_iff = 1; end

        check({tag, "/ctrl"},
              {24'd0, pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
               ex_mem_bubble, back_stall, long_busy},
              {24'd0, e_pc, e_ifs, e_iff, e_ids, e_idf, e_bub, e_back, (!rst && busy)});
        check({tag, "/cnt"},     32'(stall_cnt),   32'(m_stalls > 65535 ? 65535 : m_stalls));
        check({tag, "/cnt_sat"}, 32'(s_stall_cnt), 32'(m_stalls > 15 ? 15 : m_stalls));
        check({tag, "/excl"}, 32'((if_id_flush & if_id_stall) | (id_ex_flush & id_ex_stall)), 32'd0);

        if (rst) begin
            m_age = 0; m_stalls = 0;
        end else begin
            if (e_pc) m_stalls++;
            if (!dmem) begin
                if (busy)        m_age = (m_age == LAT - 1) ? 0 : m_age + 1;
                else if (lstall) m_age = 1;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        cycle("reset");
        rst = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        cycle("reset0");
        cycle("reset1");
        rst = 1'b0;
        check("reset_cnt",  32'(stall_cnt), 32'd0);
        check("reset_busy", 32'(long_busy), 32'd0);

        // Load-use: lw x5 in EX, add x6,x5,x1 in ID.
        is_load = 1; wb_en = 1; rd = 5'd5; rs1 = 5'd5; rs2 = 5'd1; rs1_used = 1; rs2_used = 1;
        cycle("lu_hit");
        is_load = 0; wb_en = 0;
        cycle("lu_clear");
        check("lu_cnt", 32'(stall_cnt), 32'd1);
        is_load = 1; wb_en = 1; rd = 5'd0; rs1 = 5'd0;
        cycle("lu_x0");
        check("lu_x0_cnt", 32'(stall_cnt), 32'd1);

        // Long op of 4 cycles: 3 stalls then release.
        do_reset();
        is_long = 1;
        for (int i = 0; i < 4; i++) cycle("long");
        is_long = 0;
        cycle("long_after");
        check("long_cnt",  32'(stall_cnt), 32'd3);
        check("long_idle", 32'(long_busy), 32'd0);

        // Branch with imem busywait and a load-use match: redirect wins.
        is_load = 1; wb_en = 1; rd = 5'd7; rs2 = 5'd7; rs2_used = 1;
        branch = 1; imem = 1;
        cycle("br_imem");
        check("br_cnt", 32'(stall_cnt), 32'd3);
        idle_inputs();

        // dmem busywait while the long op is at cnt=1.
        do_reset();
        is_long = 1;
        cycle("dm_entry");
        cycle("dm_cnt2");
        dmem = 1;
        for (int i = 0; i < 5; i++) cycle("dm_freeze");
        dmem = 0;
        cycle("dm_last");
        cycle("dm_release");
        is_long = 0;
        check("dm_cnt",  32'(stall_cnt), 32'd8);
        check("dm_busy", 32'(long_busy), 32'd0);

        // Reset while LONG with cnt=2.
        do_reset();
        is_long = 1;
        cycle("rl_entry");
        rst = 1;
        cycle("rl_reset");
        rst = 0; is_long = 0;
        check("rl_busy", 32'(long_busy), 32'd0);
        check("rl_cnt",  32'(stall_cnt), 32'd0);
        cycle("rl_after");

        // Saturation of the 4-bit counter.
        do_reset();
        imem = 1;
        for (int i = 0; i < 20; i++) cycle("sat");
        imem = 0;
        check("sat4",  32'(s_stall_cnt), 32'd15);
        check("sat16", 32'(stall_cnt),   32'd20);

        // Random traffic with small register indices to provoke matches.
        for (int i = 0; i < 1500; i++) begin
            rst      = ($urandom_range(63) == 0);
            dmem     = ($urandom_range(7) == 0);
            imem     = ($urandom_range(3) == 0);
            branch   = ($urandom_range(5) == 0);
            is_long  = ($urandom_range(3) == 0);
            is_load  = $urandom_range(1);
            wb_en    = $urandom_range(1);
            rs1_used = $urandom_range(1);
            rs2_used = $urandom_range(1);
            rd       = 5'($urandom_range(3));
            rs1      = 5'($urandom_range(3));
            rs2      = 5'($urandom_range(3));
            cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
